// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Imported by serial_adder and by anything that needs its state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter width; a 2-bit operand still needs one counter bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell, written as plain gate equations.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic ab_xor;
  logic ab_and;
  logic cx_and;

  assign ab_xor = a ^ b;
  assign ab_and = a & b;
  assign cx_and = ab_xor & c_in;
  assign sum    = ab_xor ^ c_in;
  assign c_out  = ab_and | cx_and;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell, LSB first, with the carry
// looped through a flop. Legal WIDTH range is 2..32.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] a_sh_next;
  logic [WIDTH-1:0] b_sh_next;
  // Bit 0 of the accumulator is only consumed on the completion edge,
  // where it comes straight from the next-value vector, so it is not stored.
  logic [WIDTH-1:1] acc_reg;
  logic [WIDTH-1:0] acc_next;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic fa_sum;
  logic fa_cout;
  logic cnt_last;

  fulladder u_fa (
    .a     (a_sh_reg[0]),
    .b     (b_sh_reg[0]),
    .c_in  (carry_reg),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign a_sh_next[gi] = 1'b0;
        assign b_sh_next[gi] = 1'b0;
        assign acc_next[gi]  = fa_sum;
      end else begin : g_low
        assign a_sh_next[gi] = a_sh_reg[gi+1];
        assign b_sh_next[gi] = b_sh_reg[gi+1];
        assign acc_next[gi]  = acc_reg[gi+1];
      end
    end
  endgenerate

  assign cnt_last = (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          // DONE accepts a start exactly like IDLE so operations can chain.
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            carry_reg <= c_in;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          a_sh_reg  <= a_sh_next;
          b_sh_reg  <= b_sh_next;
          acc_reg   <= acc_next[WIDTH-1:1];
          carry_reg <= fa_cout;
          if (cnt_last) begin
            sum_reg   <= acc_next;
            cout_reg  <= fa_cout;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign sum   = sum_reg;
  assign c_out = cout_reg;

endmodule
